// File: rtl/rle_enc_p.sv
// rtl/rle_enc_p.sv - bit-serial run-length encoder between an input FIFO and an output FIFO
module rle_enc_p #(
    parameter int IN_W      = 8,
    parameter int CNT_W     = 23,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recv_ready,
    input  logic             send_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             end_of_stream,
    output logic             rd_req,
    output logic             wr_req,
    output logic [CNT_W:0]   out_data,
    output logic             done
);

    localparam int BW = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [BW-1:0]    BITS_FULL = BW'(IN_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LOAD = 3'd2,
        SCAN = 3'd3,
        HOLD = 3'd4,
        PUSH = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [IN_W-1:0]   shift_buf, shift_buf_n;
    logic [BW-1:0]     bits_left, bits_left_n;
    logic              value, value_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              flushing, flushing_n;
    logic              scan_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_buf <= '0;
            bits_left <= '0;
            value     <= 1'b0;
            count     <= '0;
            flushing  <= 1'b0;
        end else begin
            state     <= state_n;
            shift_buf <= shift_buf_n;
            bits_left <= bits_left_n;
            value     <= value_n;
            count     <= count_n;
            flushing  <= flushing_n;
        end
    end

    always_comb begin
        state_n     = state;
        shift_buf_n = shift_buf;
        bits_left_n = bits_left;
        value_n     = value;
        count_n     = count;
        flushing_n  = flushing;
        scan_bit    = LSB_FIRST ? shift_buf[0] : shift_buf[IN_W-1];

        case (state)
            IDLE: begin
                if (recv_ready) begin
                    state_n = REQ;
                end else if (end_of_stream) begin
                    if (count != '0) begin
                        flushing_n = 1'b1;
                        state_n    = HOLD;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            REQ: state_n = LOAD;
            LOAD: begin
                shift_buf_n = in_data;
                bits_left_n = BITS_FULL;
                state_n     = SCAN;
            end
            SCAN: begin
                // A saturated run is closed without consuming the bit, so it reopens the next run.
                if ((count == '0) || ((scan_bit == value) && (count != CNT_MAX))) begin
                    if (count == '0) begin
                        value_n = scan_bit;
                        count_n = CNT_W'(1);
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                    shift_buf_n = LSB_FIRST ? (shift_buf >> 1) : (shift_buf << 1);
                    bits_left_n = bits_left - BW'(1);
                    state_n     = (bits_left == BW'(1)) ? IDLE : SCAN;
                end else begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (send_ready) begin
                    state_n = PUSH;
                end
            end
            PUSH: begin
                count_n = '0;
                if (flushing) begin
                    state_n = DONE;
                end else if (bits_left != '0) begin
                    state_n = SCAN;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                flushing_n = 1'b0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_req   = (state == REQ);
    assign wr_req   = (state == PUSH);
    assign done     = (state == DONE);
    assign out_data = {value, count};

endmodule

// File: tb/tb_rle_enc_p.sv
// tb/tb_rle_enc_p.sv - directed self-checking bench driving three encoder configurations in lockstep
module tb_rle_enc_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        recv_ready;
    logic        send_ready;
    logic [7:0]  in_data;
    logic        end_of_stream;

    logic        rd_a, wr_a, done_a;
    logic        rd_b, wr_b, done_b;
    logic        rd_c, wr_c, done_c;
    logic [23:0] out_a;
    logic [3:0]  out_b;
    logic [23:0] out_c;

    logic [23:0] qa[$], qb[$], qc[$];
    logic [23:0] ea[$], eb[$], ec[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // a: LSB first, wide count; b: LSB first, 3-bit count; c: MSB first, wide count
    rle_enc_p #(.IN_W(8), .CNT_W(23), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .recv_ready(recv_ready), .send_ready(send_ready),
        .in_data(in_data), .end_of_stream(end_of_stream),
        .rd_req(rd_a), .wr_req(wr_a), .out_data(out_a), .done(done_a));

    rle_enc_p #(.IN_W(8), .CNT_W(3), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .recv_ready(recv_ready), .send_ready(send_ready),
        .in_data(in_data), .end_of_stream(end_of_stream),
        .rd_req(rd_b), .wr_req(wr_b), .out_data(out_b), .done(done_b));

    rle_enc_p #(.IN_W(8), .CNT_W(23), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst(rst), .recv_ready(recv_ready), .send_ready(send_ready),
        .in_data(in_data), .end_of_stream(end_of_stream),
        .rd_req(rd_c), .wr_req(wr_c), .out_data(out_c), .done(done_c));

    always @(negedge clk) begin
        if (rst) begin
            if (wr_a) qa.push_back(out_a);
            if (wr_b) qb.push_back(24'(out_b));
            if (wr_c) qc.push_back(out_c);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_recs(input string tag);
        chk({tag, "_na"}, qa.size(), ea.size());
        chk({tag, "_nb"}, qb.size(), eb.size());
        chk({tag, "_nc"}, qc.size(), ec.size());
        for (int i = 0; i < ea.size(); i++)
            if (i < qa.size()) chk({tag, "_a"}, 32'(qa[i]), 32'(ea[i]));
        for (int i = 0; i < eb.size(); i++)
            if (i < qb.size()) chk({tag, "_b"}, 32'(qb[i]), 32'(eb[i]));
        for (int i = 0; i < ec.size(); i++)
            if (i < qc.size()) chk({tag, "_c"}, 32'(qc[i]), 32'(ec[i]));
        qa.delete(); qb.delete(); qc.delete();
    endtask

    // Called at a negedge with all encoders idle; returns wait_cyc negedges after LOAD starts.
    task automatic send_word(input logic [7:0] w, input int wait_cyc);
        in_data    = w;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
        chk("rd_req_pulse", {29'd0, rd_a, rd_b, rd_c}, 32'b111);
        @(negedge clk);
        chk("rd_req_single", {29'd0, rd_a, rd_b, rd_c}, 32'b000);
        repeat (wait_cyc) @(negedge clk);
    endtask

    task automatic flush_open();
        end_of_stream = 1'b1;
        @(negedge clk);
        end_of_stream = 1'b0;
        chk("flush_hold_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b000);
        @(negedge clk);
        chk("flush_push_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b111);
        @(negedge clk);
        chk("flush_done", {29'd0, done_a, done_b, done_c}, 32'b111);
        chk("flush_done_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b000);
        @(negedge clk);
        chk("flush_done_end", {29'd0, done_a, done_b, done_c}, 32'b000);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {23'd0, rd_a, wr_a, done_a, rd_b, wr_b, done_b, rd_c, wr_c, done_c}, 32'd0);
        chk({tag, "_out_a"}, 32'(out_a), 32'd0);
        chk({tag, "_out_b"}, 32'(out_b), 32'd0);
        chk({tag, "_out_c"}, 32'(out_c), 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        recv_ready    = 1'b0;
        send_ready    = 1'b1;
        in_data       = 8'h00;
        end_of_stream = 1'b0;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        send_word(8'h0F, 40);
        flush_open();
        ea = '{24'h800004, 24'h000004};
        eb = '{24'hC, 24'h4};
        ec = '{24'h000004, 24'h800004};
        check_recs("w0f");

        send_word(8'hFF, 40);
        send_word(8'hFF, 40);
        send_word(8'h00, 40);
        flush_open();
        ea = '{24'h800010, 24'h000008};
        eb = '{24'hF, 24'hF, 24'hA, 24'h7, 24'h1};
        ec = '{24'h800010, 24'h000008};
        check_recs("span");

        send_word(8'hFF, 40);
        flush_open();
        ea = '{24'h800008};
        eb = '{24'hF, 24'h9};
        ec = '{24'h800008};
        check_recs("sat");

        send_word(8'h80, 40);
        flush_open();
        ea = '{24'h000007, 24'h800001};
        eb = '{24'h7, 24'h9};
        ec = '{24'h800001, 24'h000007};
        check_recs("w80");

        // Backpressure: all three reach HOLD on the 7th edge after recv_ready is sampled.
        send_ready = 1'b0;
        send_word(8'h0F, 6);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b000);
            chk("bp_rd", {29'd0, rd_a, rd_b, rd_c}, 32'b000);
            chk("bp_out_a", 32'(out_a), 32'h800004);
            chk("bp_out_b", 32'(out_b), 32'hC);
            chk("bp_out_c", 32'(out_c), 32'h000004);
            @(negedge clk);
        end
        send_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b111);
        chk("bp_release_out_a", 32'(out_a), 32'h800004);
        @(negedge clk);
        chk("bp_single_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b000);
        repeat (15) @(negedge clk);
        flush_open();
        ea = '{24'h800004, 24'h000004};
        eb = '{24'hC, 24'h4};
        ec = '{24'h000004, 24'h800004};
        check_recs("bp");

        // Asynchronous reset in the middle of a scan.
        send_word(8'h0F, 3);
        chk("pre_reset_out_a", 32'(out_a), 32'h800002);
        #2;
        rst = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        qa.delete(); qb.delete(); qc.delete();

        send_word(8'hAA, 40);
        flush_open();
        ea = '{24'h000001, 24'h800001, 24'h000001, 24'h800001,
               24'h000001, 24'h800001, 24'h000001, 24'h800001};
        eb = '{24'h1, 24'h9, 24'h1, 24'h9, 24'h1, 24'h9, 24'h1, 24'h9};
        ec = '{24'h800001, 24'h000001, 24'h800001, 24'h000001,
               24'h800001, 24'h000001, 24'h800001, 24'h000001};
        check_recs("post_reset");

        end_of_stream = 1'b1;
        @(negedge clk);
        end_of_stream = 1'b0;
        chk("empty_done", {29'd0, done_a, done_b, done_c}, 32'b111);
        chk("empty_wr", {29'd0, wr_a, wr_b, wr_c}, 32'b000);
        @(negedge clk);
        chk("empty_done_end", {29'd0, done_a, done_b, done_c}, 32'b000);
        repeat (3) @(negedge clk);
        ea.delete(); eb.delete(); ec.delete();
        check_recs("empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
